// File: rtl/lzc_pkg.sv
// Shared types and elaboration helpers for the pipelined leading-count unit.
package lzc_pkg;

    typedef enum logic [1:0] {
        LZ  = 2'd0,
        LO  = 2'd1,
        RUN = 2'd2
    } lzc_mode_e;

    localparam int unsigned LZC_CW = 16;

    typedef struct packed {
        logic              v;
        logic [LZC_CW-1:0] c;
    } lzc_node_t;

    function automatic int unsigned clog2_p(input int unsigned width);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < width) r++;
        return r;
    endfunction

    // Tree levels completed by the end of stage s; earlier stages absorb the remainder.
    function automatic int unsigned lvl_end(input int unsigned nl, input int unsigned stages,
                                            input int unsigned s);
        int unsigned base;
        int unsigned extra;
        base  = nl / stages;
        extra = nl % stages;
        return (s + 1) * base + (((s + 1) < extra) ? (s + 1) : extra);
    endfunction

    // Stage whose register sits after tree level l, or stages when level l is combinational.
    function automatic int unsigned cut_stage(input int unsigned nl, input int unsigned stages,
                                              input int unsigned l);
        int unsigned r;
        r = stages;
        for (int unsigned s = 0; s + 1 < stages; s++)
            if (lvl_end(nl, stages, s) == l) r = s;
        return r;
    endfunction

endpackage

// File: rtl/lzc_merge.sv
// Radix-2 leading-count node: combines left/right subtrees of 2**LVL leaves each.
module lzc_merge
    import lzc_pkg::*;
#(
    parameter int unsigned LVL = 0
) (
    input  lzc_node_t left,
    input  lzc_node_t right,
    output lzc_node_t parent
);

    always_comb begin
        parent.v = left.v | right.v;
        parent.c = left.v ? left.c : (right.c | (LZC_CW'(1) << LVL));
    end

endmodule

// File: rtl/lzc_pipe.sv
// Elastic pipelined leading zero/one/regime-run counter with tag passthrough.
// Define LZC_NORM_EN to add the o_norm output (operand shifted left by the count).
module lzc_pipe
    import lzc_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [WIDTH-1:0]        i_data,
    input  logic [1:0]              i_mode,
    input  logic [TAG_W-1:0]        i_tag,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [clog2_p(WIDTH):0] o_cnt,
    output logic                    o_all,
`ifdef LZC_NORM_EN
    output logic [TAG_W-1:0]        o_tag,
    output logic [WIDTH-1:0]        o_norm
`else
    output logic [TAG_W-1:0]        o_tag
`endif
);

    localparam int unsigned NL = clog2_p(WIDTH);
    localparam int unsigned P  = 1 << NL;
    localparam int unsigned NN = 2 * P - 1;
    localparam int unsigned CW = NL + 1;

    lzc_mode_e        mode;
    logic [WIDTH-1:0] x;
    logic [P-1:0]     op;
    logic             vin  [0:STAGES];
    logic             take [0:STAGES];
    logic [TAG_W-1:0] tag_in [0:STAGES-1];
`ifdef LZC_NORM_EN
    logic [WIDTH-1:0] dat_in [0:STAGES-1];
`endif
    lzc_node_t        node [0:NN-1];
    lzc_node_t        mrg  [0:P-2];
    lzc_node_t        root;
    logic [CW-1:0]    cnt_f;
    logic             all_f;

    assign mode = lzc_mode_e'(i_mode);

    // LSB-side padding with 1s keeps the count saturated at WIDTH for non-pow2 widths.
    always_comb begin
        case (mode)
            LO:      x = ~i_data;
            RUN:     x = i_data ^ {WIDTH{i_data[WIDTH-1]}};
            default: x = i_data;
        endcase
        op = '1;
        op[P-1 -: WIDTH] = x;
    end

    for (genvar i = 0; i < P; i++) begin : g_leaf
        assign node[i] = '{v: op[P-1-i], c: '0};
    end

    assign vin[0]       = i_valid;
    assign take[STAGES] = i_ready;
    assign tag_in[0]    = i_tag;
`ifdef LZC_NORM_EN
    assign dat_in[0]    = i_data;
`endif
    assign o_ready      = take[0];
    assign o_valid      = vin[STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        logic v_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       v_q <= 1'b0;
            else if (take[s]) v_q <= vin[s];
        end
        assign vin[s+1] = v_q;
        assign take[s]  = !v_q | take[s+1];

        if (s < STAGES - 1) begin : g_mid
            logic [TAG_W-1:0] tag_q;
`ifdef LZC_NORM_EN
            logic [WIDTH-1:0] dat_q;
            always_ff @(posedge clk) if (take[s]) dat_q <= dat_in[s];
            assign dat_in[s+1] = dat_q;
`endif
            always_ff @(posedge clk) if (take[s]) tag_q <= tag_in[s];
            assign tag_in[s+1] = tag_q;
        end
    end

    // Node storage is flattened level by level: level l starts at 2P - 2*(P >> l).
    for (genvar l = 1; l <= NL; l++) begin : g_lvl
        localparam int unsigned N  = P >> l;
        localparam int unsigned OI = 2 * P - 2 * (P >> (l - 1));
        localparam int unsigned OO = 2 * P - 2 * N;
        localparam int unsigned CS = cut_stage(NL, STAGES, l);

        for (genvar i = 0; i < N; i++) begin : g_node
            lzc_merge #(.LVL(l - 1)) u_merge (
                .left  (node[OI+2*i]),
                .right (node[OI+2*i+1]),
                .parent(mrg[OO-P+i])
            );
        end

        if (CS < STAGES) begin : g_cut
            lzc_node_t q [0:N-1];
            always_ff @(posedge clk)
                if (take[CS])
                    for (int unsigned i = 0; i < N; i++) q[i] <= mrg[OO-P+i];
            for (genvar i = 0; i < N; i++) begin : g_o
                assign node[OO+i] = q[i];
            end
        end else begin : g_comb
            for (genvar i = 0; i < N; i++) begin : g_o
                assign node[OO+i] = mrg[OO-P+i];
            end
        end
    end

    assign root = node[NN-1];

    always_comb begin
        cnt_f = root.v ? root.c[CW-1:0] : CW'(P);
        all_f = (cnt_f == CW'(WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt  <= '0;
            o_all  <= 1'b0;
            o_tag  <= '0;
`ifdef LZC_NORM_EN
            o_norm <= '0;
`endif
        end else if (take[STAGES-1] && vin[STAGES-1]) begin
            o_cnt  <= cnt_f;
            o_all  <= all_f;
            o_tag  <= tag_in[STAGES-1];
`ifdef LZC_NORM_EN
            o_norm <= dat_in[STAGES-1] << cnt_f;
`endif
        end
    end

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed and randomised checks of lzc_pipe at 32b/2-stage and 20b/1-stage.
`timescale 1ns/1ps
module tb_lzc_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        a_iv, a_or, a_ov, a_ir, a_all;
    logic [31:0] a_d;
    logic [1:0]  a_m;
    logic [3:0]  a_ti, a_to;
    logic [5:0]  a_cnt;
`ifdef LZC_NORM_EN
    logic [31:0] a_norm;
    logic [19:0] b_norm;
`endif

    logic        b_iv, b_or, b_ov, b_ir, b_all;
    logic [19:0] b_d;
    logic [1:0]  b_m;
    logic [3:0]  b_ti, b_to;
    logic [5:0]  b_cnt;

    lzc_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .i_valid(a_iv), .o_ready(a_or), .i_data(a_d),
        .i_mode(a_m), .i_tag(a_ti), .o_valid(a_ov), .i_ready(a_ir), .o_cnt(a_cnt),
        .o_all(a_all), .o_tag(a_to)
`ifdef LZC_NORM_EN
        , .o_norm(a_norm)
`endif
    );

    lzc_pipe #(.WIDTH(20), .STAGES(1), .TAG_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .i_valid(b_iv), .o_ready(b_or), .i_data(b_d),
        .i_mode(b_m), .i_tag(b_ti), .o_valid(b_ov), .i_ready(b_ir), .o_cnt(b_cnt),
        .o_all(b_all), .o_tag(b_to)
`ifdef LZC_NORM_EN
        , .o_norm(b_norm)
`endif
    );

    function automatic int ref_cnt(input logic [31:0] d, input int w, input logic [1:0] m);
        logic [31:0] xv;
        int n;
        bit found;
        xv = d;
        if (m == 2'd1 || (m == 2'd2 && d[w-1])) xv = ~d;
        n = 0;
        found = 0;
        for (int i = w - 1; i >= 0; i--)
            if (!found) begin
                if (xv[i]) found = 1;
                else n++;
            end
        return n;
    endfunction

    // Sends one beat into u_a and waits (bounded) for its result; lat=99 on timeout.
    task automatic beat_a(input logic [31:0] d, input logic [1:0] m, input logic [3:0] t,
                          output int lat);
        @(negedge clk);
        a_iv = 1'b1; a_d = d; a_m = m; a_ti = t;
        @(negedge clk);
        a_iv = 1'b0; a_d = ~d; a_m = 2'd1; a_ti = ~t;
        lat = 1;
        while (!a_ov && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!a_ov) lat = 99;
    endtask

    task automatic beat_b(input logic [19:0] d, input logic [1:0] m, input logic [3:0] t,
                          output int lat);
        @(negedge clk);
        b_iv = 1'b1; b_d = d; b_m = m; b_ti = t;
        @(negedge clk);
        b_iv = 1'b0; b_d = ~d; b_ti = ~t;
        lat = 1;
        while (!b_ov && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!b_ov) lat = 99;
    endtask

    task automatic test_reset();
        a_iv = 0; a_d = '0; a_m = 0; a_ti = 0; a_ir = 1;
        b_iv = 0; b_d = '0; b_m = 0; b_ti = 0; b_ir = 1;
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (a_ov !== 1'b0 || a_cnt !== 6'd0 || a_all !== 1'b0 || a_to !== 4'd0) begin
            failures++;
            $display("FAIL reset_a: ov=%b cnt=%0d all=%b tag=%0d, want 0 0 0 0", a_ov, a_cnt, a_all, a_to);
        end
        checks++;
        if (b_ov !== 1'b0 || b_cnt !== 6'd0 || b_all !== 1'b0 || b_to !== 4'd0) begin
            failures++;
            $display("FAIL reset_b: ov=%b cnt=%0d all=%b tag=%0d, want 0 0 0 0", b_ov, b_cnt, b_all, b_to);
        end
        rst_n = 1;
        #1;
        checks++;
        if (a_or !== 1'b1 || b_or !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: a=%b b=%b, want 1 1", a_or, b_or);
        end
    endtask

    task automatic test_lz();
        int lat;
        beat_a(32'h0001_0000, 2'd0, 4'h3, lat);
        checks++;
        if (lat !== 2 || a_cnt !== 6'd15 || a_all !== 1'b0 || a_to !== 4'h3) begin
            failures++;
            $display("FAIL lz_0x10000: lat=%0d cnt=%0d all=%b tag=%0d, want 2 15 0 3", lat, a_cnt, a_all, a_to);
        end
        beat_a(32'h0, 2'd0, 4'h5, lat);
        checks++;
        if (lat !== 2 || a_cnt !== 6'd32 || a_all !== 1'b1 || a_to !== 4'h5) begin
            failures++;
            $display("FAIL lz_zero: lat=%0d cnt=%0d all=%b tag=%0d, want 2 32 1 5", lat, a_cnt, a_all, a_to);
        end
    endtask

    task automatic test_modes();
        logic [31:0] td [9];
        logic [1:0]  tm [9];
        int          tc [9];
        int lat;
        td = '{32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000, 32'h0000_0FFF, 32'hFFFF_FFFF,
               32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        tm = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd0};
        tc = '{12, 12, 0, 20, 32, 15, 1, 1, 31};
        for (int i = 0; i < 9; i++) begin
            beat_a(td[i], tm[i], 4'(i), lat);
            checks++;
            if (lat !== 2 || a_cnt !== 6'(tc[i]) || a_all !== (tc[i] == 32) || a_to !== 4'(i)) begin
                failures++;
                $display("FAIL mode_vec%0d: lat=%0d cnt=%0d all=%b tag=%0d, want 2 %0d %b %0d",
                         i, lat, a_cnt, a_all, a_to, tc[i], tc[i] == 32, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit held = 0;
        bit saw_full = 0;
        bit extra = 0;
        logic [3:0] h_tag;
        logic [5:0] h_cnt;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            a_ir = !(cyc >= 3 && cyc < 8);
            if (sent < 8) begin
                a_iv = 1; a_d = 32'h8000_0000 >> (3 * sent); a_m = 2'd0; a_ti = 4'(sent);
            end else begin
                a_iv = 0;
            end
            #1;
            if (held) begin
                checks++;
                if (a_ov !== 1'b1 || a_to !== h_tag || a_cnt !== h_cnt) begin
                    failures++;
                    $display("FAIL stall_stable: ov=%b tag=%0d cnt=%0d, want 1 %0d %0d", a_ov, a_to, a_cnt, h_tag, h_cnt);
                end
            end
            if (!a_ir && !a_or) saw_full = 1;
            if (a_ov && a_ir) begin
                checks++;
                if (a_to !== 4'(got) || a_cnt !== 6'(3 * got)) begin
                    failures++;
                    $display("FAIL bp_order: tag=%0d cnt=%0d, want %0d %0d", a_to, a_cnt, got, 3 * got);
                end
                got++;
            end
            held = a_ov && !a_ir;
            h_tag = a_to;
            h_cnt = a_cnt;
            if (a_iv && a_or) sent++;
            cyc++;
        end
        a_iv = 0;
        a_ir = 1;
        checks++;
        if (got !== 8) begin
            failures++;
            $display("FAIL bp_count: got %0d beats, want 8", got);
        end
        checks++;
        if (!saw_full) begin
            failures++;
            $display("FAIL bp_ready_drop: o_ready never low while stalled, want low");
        end
        repeat (4) begin
            @(negedge clk);
            if (a_ov) extra = 1;
        end
        checks++;
        if (extra) begin
            failures++;
            $display("FAIL bp_no_dup: extra output after 8 beats, want none");
        end
    endtask

    task automatic test_reset_mid();
        bit stale = 0;
        @(negedge clk);
        a_ir = 0; a_iv = 1; a_d = 32'h0; a_m = 2'd0; a_ti = 4'd9;
        @(negedge clk);
        a_d = 32'h0000_FFFF; a_ti = 4'd10;
        @(negedge clk);
        a_iv = 0;
        #1;
        checks++;
        if (a_ov !== 1'b1 || a_to !== 4'd9 || a_cnt !== 6'd32) begin
            failures++;
            $display("FAIL pre_reset_full: ov=%b tag=%0d cnt=%0d, want 1 9 32", a_ov, a_to, a_cnt);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (a_ov !== 1'b0 || a_cnt !== 6'd0 || a_all !== 1'b0 || a_to !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: ov=%b cnt=%0d all=%b tag=%0d, want 0 0 0 0", a_ov, a_cnt, a_all, a_to);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        a_ir = 1;
        #1;
        checks++;
        if (a_or !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_ready: o_ready=%b, want 1", a_or);
        end
        repeat (5) begin
            @(negedge clk);
            if (a_ov) stale = 1;
        end
        checks++;
        if (stale) begin
            failures++;
            $display("FAIL mid_reset_stale: o_valid=1 after release, want 0");
        end
    endtask

    task automatic test_w20();
        typedef struct packed {
            logic [5:0] cnt;
            logic       all;
            logic [3:0] tag;
        } exp_t;
        exp_t q[$];
        exp_t e;
        int lat, c;
        int sent = 0;
        int cyc = 0;
        logic [19:0] d;
        beat_b(20'h00001, 2'd0, 4'h1, lat);
        checks++;
        if (lat !== 1 || b_cnt !== 6'd19 || b_all !== 1'b0 || b_to !== 4'h1) begin
            failures++;
            $display("FAIL w20_one: lat=%0d cnt=%0d all=%b tag=%0d, want 1 19 0 1", lat, b_cnt, b_all, b_to);
        end
        beat_b(20'h00000, 2'd0, 4'h2, lat);
        checks++;
        if (lat !== 1 || b_cnt !== 6'd20 || b_all !== 1'b1 || b_to !== 4'h2) begin
            failures++;
            $display("FAIL w20_zero: lat=%0d cnt=%0d all=%b tag=%0d, want 1 20 1 2", lat, b_cnt, b_all, b_to);
        end
        while ((sent < 10000 || q.size() > 0) && cyc < 40000) begin
            @(negedge clk);
            b_ir = ($urandom_range(0, 3) != 0);
            if (sent < 10000) begin
                b_iv = ($urandom_range(0, 7) != 0);
                d = 20'($urandom) & (20'hFFFFF >> $urandom_range(0, 20));
                if ($urandom_range(0, 1) == 1) d = ~d;
                b_d = d;
                b_m = 2'($urandom_range(0, 3));
                b_ti = 4'($urandom);
            end else begin
                b_iv = 0;
            end
            #1;
            if (b_ov && b_ir) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL w20_rand_extra: unexpected beat tag=%0d, want none", b_to);
                end else begin
                    e = q.pop_front();
                    if ({b_cnt, b_all, b_to} !== e) begin
                        failures++;
                        $display("FAIL w20_rand: cnt=%0d all=%b tag=%0d, want %0d %b %0d",
                                 b_cnt, b_all, b_to, e.cnt, e.all, e.tag);
                    end
                end
            end
            if (b_iv && b_or) begin
                c = ref_cnt({12'd0, b_d}, 20, b_m);
                q.push_back('{cnt: 6'(c), all: (c == 20), tag: b_ti});
                sent++;
            end
            cyc++;
        end
        b_iv = 0;
        b_ir = 1;
        checks++;
        if (sent !== 10000 || q.size() !== 0) begin
            failures++;
            $display("FAIL w20_rand_drain: sent=%0d pending=%0d, want 10000 0", sent, q.size());
        end
    endtask

`ifdef LZC_NORM_EN
    task automatic test_norm();
        int lat;
        beat_a(32'h0000_00A5, 2'd0, 4'h6, lat);
        checks++;
        if (a_cnt !== 6'd24 || a_norm !== 32'hA500_0000) begin
            failures++;
            $display("FAIL norm_a5: cnt=%0d norm=%h, want 24 a5000000", a_cnt, a_norm);
        end
        beat_a(32'h0, 2'd0, 4'h7, lat);
        checks++;
        if (a_all !== 1'b1 || a_norm !== 32'h0) begin
            failures++;
            $display("FAIL norm_zero: all=%b norm=%h, want 1 00000000", a_all, a_norm);
        end
        beat_a(32'h0F00_0000, 2'd2, 4'h8, lat);
        checks++;
        if (a_cnt !== 6'd4 || a_norm !== 32'hF000_0000) begin
            failures++;
            $display("FAIL norm_run: cnt=%0d norm=%h, want 4 f0000000", a_cnt, a_norm);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lz();
        test_modes();
        test_back_to_back();
        test_reset_mid();
        test_w20();
`ifdef LZC_NORM_EN
        test_norm();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
